iformat_exec_unit: RTL and testbench



---
 rtl/iformat_pkg.sv | 37 +++
 rtl/iformat_regfile_2r1w.sv | 33 +++
 rtl/iformat_exec_unit.sv | 152 +++++++++++++++
 tb/tb_iformat_exec_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iformat_pkg.sv
// Shared constants for the I-format execution unit: opcodes, sequencer
// state encodings and instruction field positions.
package iformat_pkg;

  // Opcode field values
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  // Sequencer state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_EX   = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  // Instruction field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // True for the opcodes the ALU implements
  function automatic logic is_legal_op(input logic [5:0] opc);
    return (opc == OP_ADDI) || (opc == OP_SUBI) || (opc == OP_SLTI) ||
           (opc == OP_ANDI) || (opc == OP_ORI)  || (opc == OP_XORI) ||
           (opc == OP_LUI);
  endfunction

endpackage

// File: rtl/iformat_regfile_2r1w.sv
// Register array with one write port and two combinational read ports
// (operand read and debug read). r0 always reads as zero and ignores writes.
module iformat_regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Synchronous clear on reset, otherwise single write port (r0 discarded)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata    = (raddr == '0)    ? '0 : regs[raddr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/iformat_exec_unit.sv
// I-format execution unit: register file plus a four-state sequencer
// (IDLE -> RD -> EX -> WB) running one instruction at a time.
// Optional macro OVERFLOW_TRAP_EN: ADDI/SUBI signed overflow reports err and
// suppresses the writeback (result still shows the wrapped value).
module iformat_exec_unit
  import iformat_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  parameter  int IMM_W  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] dbg_data
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1. instr_ready is 1 only in IDLE (and never during a
  // reset cycle); instr_valid/instr are ignored whenever instr_ready is 0.

  logic [1:0]        state_q;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] result_q;
  logic              err_q;

  logic [5:0]        opc;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_z;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_res;
  logic              alu_err;

  assign opc   = instr_q[OPC_HI:OPC_LO];
  assign rs    = ADDR_W'(instr_q[RS_HI:RS_LO]);
  assign rt    = ADDR_W'(instr_q[RT_HI:RT_LO]);
  assign imm   = instr_q[IMM_HI:IMM_LO];
  assign imm_s = DATA_W'($signed(imm));
  assign imm_z = DATA_W'(imm);

  // Writeback owns the port in WB; external preload only lands while IDLE
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ext_addr;
    rf_wdata = ext_wdata;
    if (state_q == S_WB) begin
      rf_we    = !err_q;
      rf_waddr = rt;
      rf_wdata = result_q;
    end else if (state_q == S_IDLE) begin
      rf_we    = ext_we;
    end
  end

  iformat_regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr    (rs),
    .rdata    (rf_rdata),
    .dbg_addr (ext_addr),
    .dbg_data (dbg_data)
  );

  // ALU: result and error flag for the latched instruction and operand
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opc)
      OP_ADDI: alu_res = op_a_q + imm_s;
      OP_SUBI: alu_res = op_a_q - imm_s;
      OP_SLTI: alu_res = ($signed(op_a_q) < $signed(imm_s)) ? DATA_W'(1) : '0;
      OP_ANDI: alu_res = op_a_q & imm_z;
      OP_ORI:  alu_res = op_a_q | imm_z;
      OP_XORI: alu_res = op_a_q ^ imm_z;
      OP_LUI:  alu_res = (DATA_W == 16) ? imm_z : (imm_z << 16);
      default: alu_err = 1'b1;
    endcase
    if (!is_legal_op(opc)) begin
      alu_res = '0;
      alu_err = 1'b1;
    end
`ifdef OVERFLOW_TRAP_EN
    // Signed overflow: operands' signs (after negating for SUBI) agree but the
    // wrapped result's sign differs
    if (opc == OP_ADDI &&
        op_a_q[DATA_W-1] == imm_s[DATA_W-1] && alu_res[DATA_W-1] != op_a_q[DATA_W-1])
      alu_err = 1'b1;
    if (opc == OP_SUBI &&
        op_a_q[DATA_W-1] != imm_s[DATA_W-1] && alu_res[DATA_W-1] != op_a_q[DATA_W-1])
      alu_err = 1'b1;
`endif
  end

  // Sequencer: latch instruction, read operand, execute, retire
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      op_a_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          op_a_q  <= rf_rdata;
          state_q <= S_EX;
        end
        S_EX: begin
          result_q <= alu_res;
          err_q    <= alu_err;
          state_q  <= S_WB;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = !reset && (state_q == S_IDLE);
  assign done        = !reset && (state_q == S_WB);
  assign err         = done && err_q;
  assign result      = done ? result_q : '0;

endmodule

// File: tb/tb_iformat_exec_unit.sv
// Self-checking bench for iformat_exec_unit: directed scenarios plus random
// instructions scored against a behavioural model of the instruction set.
module tb_iformat_exec_unit;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int W      = DATA_W + 1;

  logic              clock;
  logic              reset;
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] dbg_data;

  iformat_exec_unit dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .done        (done),
    .err         (err),
    .result      (result),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .dbg_data    (dbg_data)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];     // {err, result}
  int           cyc_q[$];     // cycle count at which done must be seen
  logic [31:0]  m_regs[NREGS];
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction-set semantics in plain 64-bit signed arithmetic.
  function automatic logic [W-1:0] ref_exec(input logic [31:0] ins);
    logic [5:0]         opc;
    logic [4:0]         rs;
    logic [15:0]        im;
    logic signed [63:0] a, si, s;
    logic [31:0]        av, res;
    logic               e, ovf;
    opc = ins[31:26];
    rs  = ins[25:21];
    im  = ins[15:0];
    av  = (rs == 0) ? 32'd0 : m_regs[rs];
    a   = 64'(signed'(av));
    si  = 64'(signed'(im));
    e   = 1'b0;
    ovf = 1'b0;
    res = 32'd0;
    s   = 64'sd0;
    case (opc)
      6'd8:  begin s = a + si; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd9:  begin s = a - si; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd10: res = (a < si) ? 32'd1 : 32'd0;
      6'd12: res = av & {16'd0, im};
      6'd13: res = av | {16'd0, im};
      6'd14: res = av ^ {16'd0, im};
      6'd15: res = {im, 16'd0};
      default: e = 1'b1;
    endcase
`ifdef OVERFLOW_TRAP_EN
    if (ovf) e = 1'b1;
`endif
    return {e, res};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [W-1:0] e;
    int           c;
    if (!reset) begin
      if (err && !done) check("err_without_done", {63'd0, err}, 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("result", 64'(result), 64'(e[DATA_W-1:0]));
          check("err",    64'(err),    64'(e[DATA_W]));
          check("latency", 64'(cyc),   64'(c));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning just after a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) check("idle_timeout", {63'd0, instr_ready}, 64'd1);
  endtask

  task automatic check_reg(input logic [4:0] a, input string name);
    wait_idle();
    ext_addr = a;
    #1;
    check(name, 64'(dbg_data), 64'(m_regs[a]));
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    wait_idle();
    ext_we    = 1'b1;
    ext_addr  = a;
    ext_wdata = d;
    @(negedge clock);
    ext_we = 1'b0;
    if (a != 0) m_regs[a] = d;
  endtask

  // Issue one instruction, optionally with a same-edge preload and with
  // ext writes / instr_valid toggled while the unit is busy (must be ignored).
  task automatic issue(input logic [31:0] ins, input bit pre, input logic [4:0] pa,
                       input logic [31:0] pd, input bit noise);
    logic [W-1:0] e;
    logic [4:0]   rt;
    wait_idle();
    ext_addr = 5'($urandom_range(0, 7));
    #1;
    check("dbg_idle", 64'(dbg_data), 64'(m_regs[ext_addr]));
    if (pre) begin
      ext_we    = 1'b1;
      ext_addr  = pa;
      ext_wdata = pd;
      if (pa != 0) m_regs[pa] = pd;
    end
    instr_valid = 1'b1;
    instr       = ins;
    e  = ref_exec(ins);
    rt = ins[20:16];
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 3);
    if (!e[DATA_W] && rt != 0) m_regs[rt] = e[DATA_W-1:0];
    @(negedge clock);
    ext_we      = 1'b0;
    instr_valid = 1'b0;
    instr       = $urandom;
    if (noise) begin
      instr_valid = 1'b1;
      ext_we      = 1'b1;
      ext_addr    = 5'($urandom_range(1, 7));
      ext_wdata   = $urandom;
      @(negedge clock);
      @(negedge clock);
      instr_valid = 1'b0;
      ext_we      = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0]  legal_ops[7];
  logic [5:0]  opc;
  logic [15:0] imm;
  logic [31:0] pd;
  int          n;

  initial begin
    legal_ops = '{6'o10, 6'o11, 6'o12, 6'o14, 6'o15, 6'o16, 6'o17};
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    instr_valid = 1'b0;
    instr       = '0;
    ext_we      = 1'b0;
    ext_addr    = '0;
    ext_wdata   = '0;
    reset       = 1'b1;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_ready", {63'd0, instr_ready}, 64'd0);
    check("rst_done",  {63'd0, done},        64'd0);
    check("rst_err",   {63'd0, err},         64'd0);
    check("rst_result", 64'(result),         64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", {63'd0, instr_ready}, 64'd1);
    check_reg(5'd1, "rst_r1");

    // ADDI / ANDI / ORI basics
    preload(5'd1, 32'd212);
    issue(32'h20220001, 0, 0, 0, 0);
    check_reg(5'd2, "addi_r2");
    issue(32'h30220001, 0, 0, 0, 0);
    check_reg(5'd2, "andi_r2");
    issue(32'h34220001, 0, 0, 0, 1);
    check_reg(5'd2, "ori_r2");

    // Sign vs zero extension
    issue(32'h2022FFFF, 0, 0, 0, 0);
    check_reg(5'd2, "addi_sext_r2");
    issue(32'h3423FFFF, 0, 0, 0, 0);
    check_reg(5'd3, "ori_zext_r3");

    // r0 target, illegal opcode
    issue(32'h20200005, 0, 0, 0, 0);
    check_reg(5'd0, "r0_zero");
    issue(32'hFC220001, 0, 0, 0, 0);
    check_reg(5'd2, "illegal_r2_kept");

    // Preload coincident with accept is seen by RD
    issue(32'h20240003, 1, 5'd1, 32'd1000, 0);
    check_reg(5'd4, "same_edge_preload_r4");

    // Signed overflow (trap or wrap according to build)
    preload(5'd1, 32'h7FFFFFFF);
    issue(32'h20220001, 0, 0, 0, 0);
    check_reg(5'd2, "ovf_r2");

    // Reset during EX aborts the instruction
    wait_idle();
    preload(5'd1, 32'd212);
    instr_valid = 1'b1;
    instr       = 32'h20250001;
    @(negedge clock);           // RD
    instr_valid = 1'b0;
    @(negedge clock);           // EX
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ready", {63'd0, instr_ready}, 64'd0);
    check("midrst_done",  {63'd0, done},        64'd0);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    @(negedge clock);
    check("midrst_ready_after", {63'd0, instr_ready}, 64'd1);
    for (int i = 0; i < 4; i++) @(negedge clock);
    check_reg(5'd5, "midrst_r5");
    check_reg(5'd1, "midrst_r1");

    // Random instructions
    for (int k = 0; k < 200; k++) begin
      n   = $urandom_range(0, 9);
      opc = (n < 7) ? legal_ops[n] : 6'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
        0: imm = 16'h0000;
        1: imm = 16'hFFFF;
        2: imm = 16'h8000;
        3: imm = 16'h7FFF;
        default: imm = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: pd = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
        1: pd = 32'h80000000 + 32'($urandom_range(0, 3));
        default: pd = $urandom;
      endcase
      issue({opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm},
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), pd,
            ($urandom_range(0, 1) == 1));
    end
    for (int r = 0; r < 8; r++) check_reg(5'(r), "final_reg");

    // Drain scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
